// File: rtl/el2_iccm_bank_responder.sv
// el2_iccm_bank_responder: RAM-side ICCM bank array with 1-cycle read data
// Ports: clk/rst_l; iccm_* bank bus in, iccm_bank_dout out; flt_cfg_* program, flt_active/flt_hit_cnt status
module el2_iccm_bank_responder #(
   parameter int ICCM_NUM_BANKS     = 4,
   parameter int ICCM_BITS          = 16,
   parameter int ICCM_BANK_INDEX_LO = 4,
   parameter int FLT_SLOTS          = 2,
   parameter int CNT_W              = 8,
   localparam int NB  = ICCM_NUM_BANKS,
   localparam int RW  = ICCM_BITS - ICCM_BANK_INDEX_LO,
   localparam int BW  = (NB > 1) ? $clog2(NB) : 1,
   localparam int SW  = (FLT_SLOTS > 1) ? $clog2(FLT_SLOTS) : 1
) (
   input  logic               clk,
   input  logic               rst_l,
   input  logic [NB-1:0]      iccm_clken,
   input  logic [NB-1:0]      iccm_wren_bank,
   input  logic [NB*RW-1:0]   iccm_addr_bank,
   input  logic [NB*39-1:0]   iccm_bank_wr_data,
   output logic [NB*39-1:0]   iccm_bank_dout,
   input  logic               flt_cfg_en,
   input  logic [SW-1:0]      flt_cfg_slot,
   input  logic               flt_cfg_valid,
   input  logic               flt_cfg_persist,
   input  logic [BW-1:0]      flt_cfg_bank,
   input  logic [RW-1:0]      flt_cfg_row,
   input  logic [38:0]        flt_cfg_mask,
   output logic [FLT_SLOTS-1:0] flt_active,
   output logic [CNT_W-1:0]   flt_hit_cnt
);

   localparam int ROWS = 1 << RW;
   localparam int CW2  = CNT_W + 5;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [38:0] mem [NB][ROWS];

   logic                 slot_persist [FLT_SLOTS];
   logic [BW-1:0]        slot_bank    [FLT_SLOTS];
   logic [RW-1:0]        slot_row     [FLT_SLOTS];
   logic [38:0]          slot_mask    [FLT_SLOTS];

   logic [RW-1:0]        row_a [NB];
   logic [38:0]          fmask [NB];
   logic [NB-1:0]        rd;
   logic [NB-1:0]        rd_hit;
   logic [FLT_SLOTS-1:0] clr;
   logic [4:0]           nhits;
   logic [CW2-1:0]       cnt_sum;
   logic [CNT_W-1:0]     cnt_next;

   always_comb begin
      for (int i = 0; i < NB; i++) begin
         row_a[i] = iccm_addr_bank[i*RW +: RW];
         rd[i]    = iccm_clken[i] & ~iccm_wren_bank[i];
      end
   end

   // Slot match per bank; one-shot slots clear once even if several banks hit them
   always_comb begin
      clr    = '0;
      rd_hit = '0;
      nhits  = '0;
      for (int i = 0; i < NB; i++) begin
         fmask[i] = '0;
         for (int s = 0; s < FLT_SLOTS; s++) begin
            if (flt_active[s] && slot_bank[s] == BW'(i) &&
                slot_row[s] == row_a[i]) begin
               fmask[i] = fmask[i] ^ slot_mask[s];
               if (rd[i]) begin
                  rd_hit[i] = 1'b1;
                  if (!slot_persist[s]) clr[s] = 1'b1;
               end
            end
         end
         nhits = nhits + 5'(rd_hit[i]);
      end
      cnt_sum  = CW2'(flt_hit_cnt) + CW2'(nhits);
      cnt_next = (cnt_sum > CW2'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
   end

   // Array is never reset; faults touch only the read path
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (iccm_clken[i] && iccm_wren_bank[i])
            mem[i][row_a[i]] <= iccm_bank_wr_data[i*39 +: 39];
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         iccm_bank_dout <= '0;
      end else begin
         for (int i = 0; i < NB; i++) begin
            if (rd[i])
               iccm_bank_dout[i*39 +: 39] <= mem[i][row_a[i]] ^ fmask[i];
         end
      end
   end

   // Config write overrides a same-cycle one-shot clear
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         flt_active  <= '0;
         flt_hit_cnt <= '0;
         for (int s = 0; s < FLT_SLOTS; s++) begin
            slot_persist[s] <= 1'b0;
            slot_bank[s]    <= '0;
            slot_row[s]     <= '0;
            slot_mask[s]    <= '0;
         end
      end else begin
         flt_hit_cnt <= cnt_next;
         for (int s = 0; s < FLT_SLOTS; s++) begin
            if (flt_cfg_en && flt_cfg_slot == SW'(s)) begin
               flt_active[s]   <= flt_cfg_valid;
               slot_persist[s] <= flt_cfg_persist;
               slot_bank[s]    <= flt_cfg_bank;
               slot_row[s]     <= flt_cfg_row;
               slot_mask[s]    <= flt_cfg_mask;
            end else if (clr[s]) begin
               flt_active[s] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_el2_iccm_bank_responder.sv
// tb_el2_iccm_bank_responder: directed bench for el2_iccm_bank_responder
// Checks reset, read/write, clken gating, fault slots, saturation, mid-op reset
module tb_el2_iccm_bank_responder;

   localparam int NB = 4;
   localparam int RW = 12;

   logic              clk = 1'b0;
   logic              rst_l = 1'b0;
   logic [NB-1:0]     iccm_clken = '0;
   logic [NB-1:0]     iccm_wren_bank = '0;
   logic [NB*RW-1:0]  iccm_addr_bank = '0;
   logic [NB*39-1:0]  iccm_bank_wr_data = '0;
   logic [NB*39-1:0]  iccm_bank_dout;
   logic              flt_cfg_en = 1'b0;
   logic [0:0]        flt_cfg_slot = '0;
   logic              flt_cfg_valid = 1'b0;
   logic              flt_cfg_persist = 1'b0;
   logic [1:0]        flt_cfg_bank = '0;
   logic [RW-1:0]     flt_cfg_row = '0;
   logic [38:0]       flt_cfg_mask = '0;
   logic [1:0]        flt_active;
   logic [7:0]        flt_hit_cnt;

   int total = 0;
   int bad   = 0;

   el2_iccm_bank_responder dut (
      .clk               (clk),
      .rst_l             (rst_l),
      .iccm_clken        (iccm_clken),
      .iccm_wren_bank    (iccm_wren_bank),
      .iccm_addr_bank    (iccm_addr_bank),
      .iccm_bank_wr_data (iccm_bank_wr_data),
      .iccm_bank_dout    (iccm_bank_dout),
      .flt_cfg_en        (flt_cfg_en),
      .flt_cfg_slot      (flt_cfg_slot),
      .flt_cfg_valid     (flt_cfg_valid),
      .flt_cfg_persist   (flt_cfg_persist),
      .flt_cfg_bank      (flt_cfg_bank),
      .flt_cfg_row       (flt_cfg_row),
      .flt_cfg_mask      (flt_cfg_mask),
      .flt_active        (flt_active),
      .flt_hit_cnt       (flt_hit_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [38:0] dout(input int b);
      return iccm_bank_dout[b*39 +: 39];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int b, input logic [RW-1:0] r,
                     input logic [38:0] d);
      iccm_clken[b] = 1'b1;
      iccm_wren_bank[b] = 1'b1;
      iccm_addr_bank[b*RW +: RW] = r;
      iccm_bank_wr_data[b*39 +: 39] = d;
      tick();
      iccm_clken = '0;
      iccm_wren_bank = '0;
   endtask

   task automatic rd(input int b, input logic [RW-1:0] r);
      iccm_clken[b] = 1'b1;
      iccm_wren_bank[b] = 1'b0;
      iccm_addr_bank[b*RW +: RW] = r;
      tick();
      iccm_clken = '0;
   endtask

   task automatic cfg_set(input logic s, input logic v, input logic p,
                          input logic [1:0] b, input logic [RW-1:0] r,
                          input logic [38:0] m);
      flt_cfg_slot = s;
      flt_cfg_valid = v;
      flt_cfg_persist = p;
      flt_cfg_bank = b;
      flt_cfg_row = r;
      flt_cfg_mask = m;
   endtask

   task automatic cfg(input logic s, input logic v, input logic p,
                      input logic [1:0] b, input logic [RW-1:0] r,
                      input logic [38:0] m);
      cfg_set(s, v, p, b, r, m);
      flt_cfg_en = 1'b1;
      tick();
      flt_cfg_en = 1'b0;
   endtask

   localparam logic [38:0] D2 = 39'h12345678AB;
   localparam logic [38:0] DA = 39'h0A5A5A5A5A;
   localparam logic [38:0] DB = 39'h7FFFFFFFFF;
   localparam logic [38:0] D0 = 39'h0011223344;
   localparam logic [38:0] D3 = 39'h0055667788;
   localparam logic [38:0] D5 = 39'h3C3C3C3C3C;
   localparam logic [38:0] B38 = 39'h4000000000;

   initial begin
      // Reset
      tick();
      tick();
      chk("rst_dout", 64'(iccm_bank_dout[63:0]), 64'h0);
      chk("rst_active", 64'(flt_active), 64'h0);
      chk("rst_cnt", 64'(flt_hit_cnt), 64'h0);
      @(negedge clk);
      rst_l = 1'b1;
      tick();

      // Write then read bank2
      wr(2, 12'h011, D2);
      chk("wr_dout_hold", 64'(dout(2)), 64'h0);
      rd(2, 12'h011);
      chk("rd_b2", 64'(dout(2)), 64'(D2));
      chk("rd_b0_untouched", 64'(dout(0)), 64'h0);

      // clken gating on bank1
      wr(1, 12'h020, DA);
      rd(1, 12'h020);
      chk("rd_b1", 64'(dout(1)), 64'(DA));
      iccm_bank_wr_data[1*39 +: 39] = DB;
      for (int k = 0; k < 5; k++) begin
         iccm_wren_bank[1] = k[0];
         tick();
      end
      iccm_wren_bank = '0;
      chk("clken0_hold", 64'(dout(1)), 64'(DA));
      rd(1, 12'h020);
      chk("clken0_nowrite", 64'(dout(1)), 64'(DA));

      // One-shot fault
      wr(0, 12'h003, D0);
      cfg(1'b0, 1'b1, 1'b0, 2'd0, 12'h003, 39'h1);
      chk("os_armed", 64'(flt_active), 64'h1);
      rd(0, 12'h003);
      chk("os_rd1", 64'(dout(0)), 64'(D0 ^ 39'h1));
      chk("os_cleared", 64'(flt_active), 64'h0);
      chk("os_cnt1", 64'(flt_hit_cnt), 64'd1);
      rd(0, 12'h003);
      chk("os_rd2", 64'(dout(0)), 64'(D0));
      chk("os_cnt_hold", 64'(flt_hit_cnt), 64'd1);

      // Persistent fault survives writes
      cfg(1'b1, 1'b1, 1'b1, 2'd3, 12'h007, B38);
      wr(3, 12'h007, D3);
      for (int k = 0; k < 3; k++) begin
         rd(3, 12'h007);
         chk("ps_rd", 64'(dout(3)), 64'(D3 ^ B38));
      end
      chk("ps_cnt", 64'(flt_hit_cnt), 64'd4);
      chk("ps_active", 64'(flt_active), 64'h2);

      // Two slots on same row combine by XOR
      cfg(1'b0, 1'b1, 1'b1, 2'd1, 12'h005, 39'h3);
      cfg(1'b1, 1'b1, 1'b1, 2'd1, 12'h005, 39'h1);
      wr(1, 12'h005, D5);
      rd(1, 12'h005);
      chk("xor_rd", 64'(dout(1)), 64'(D5 ^ 39'h2));
      chk("xor_cnt", 64'(flt_hit_cnt), 64'd5);

      // Saturation
      for (int k = 0; k < 249; k++) rd(1, 12'h005);
      chk("cnt_254", 64'(flt_hit_cnt), 64'd254);
      for (int k = 0; k < 51; k++) rd(1, 12'h005);
      chk("cnt_sat", 64'(flt_hit_cnt), 64'd255);

      // Same-cycle config write: read uses old slot state
      cfg_set(1'b0, 1'b0, 1'b0, 2'd1, 12'h005, 39'h0);
      flt_cfg_en = 1'b1;
      rd(1, 12'h005);
      flt_cfg_en = 1'b0;
      chk("cfg_same_cycle", 64'(dout(1)), 64'(D5 ^ 39'h2));
      chk("cfg_disarm", 64'(flt_active), 64'h2);
      rd(1, 12'h005);
      chk("cfg_next_cycle", 64'(dout(1)), 64'(D5 ^ 39'h1));
      chk("cnt_still_sat", 64'(flt_hit_cnt), 64'd255);

      // Reset mid-operation
      cfg(1'b0, 1'b1, 1'b0, 2'd2, 12'h011, 39'hFF);
      iccm_clken[2] = 1'b1;
      iccm_addr_bank[2*RW +: RW] = 12'h011;
      @(negedge clk);
      rst_l = 1'b0;
      #1;
      chk("mid_rst_dout", 64'(dout(2)), 64'h0);
      chk("mid_rst_active", 64'(flt_active), 64'h0);
      chk("mid_rst_cnt", 64'(flt_hit_cnt), 64'h0);
      iccm_clken = '0;
      @(negedge clk);
      rst_l = 1'b1;
      rd(2, 12'h011);
      chk("post_rst_rd", 64'(dout(2)), 64'(D2));
      chk("post_rst_cnt", 64'(flt_hit_cnt), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
